// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core, its program loader and benches.
package bf_pkg;

  localparam int          BF_CODE_AW  = 9;
  localparam logic [7:0]  BF_END_CHAR = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } bf_state_e;

endpackage

// File: rtl/bf_program_loader.sv
// Code-RAM sequencer: streams a host program into code RAM with the core held
// in reset, then hands the RAM address port to the core and releases it.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int         CODE_AW  = BF_CODE_AW,
  parameter logic [7:0] END_CHAR = BF_END_CHAR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               stop,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_AW-1:0] core_addr_code,
  output logic               core_reset,
  output logic [CODE_AW-1:0] ram_addr,
  output logic [7:0]         ram_wdata,
  output logic               ram_we,
  output logic [CODE_AW-1:0] prog_len,
  output logic               running,
  output logic               overflow
);

  localparam logic [CODE_AW-1:0] LAST_ADDR = {CODE_AW{1'b1}};
  localparam logic [CODE_AW-1:0] ADDR_ONE  = {{(CODE_AW-1){1'b0}}, 1'b1};
  localparam logic [CODE_AW-1:0] ADDR_ZERO = {CODE_AW{1'b0}};

  bf_state_e          state_r;
  logic [CODE_AW-1:0] wr_ptr_r;
  logic [CODE_AW-1:0] wr_addr_r;

  // Loader FSM with the registered write port and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      wr_ptr_r   <= ADDR_ZERO;
      wr_addr_r  <= ADDR_ZERO;
      ram_we     <= 1'b0;
      ram_wdata  <= 8'h00;
      core_reset <= 1'b0;
      in_ready   <= 1'b0;
      prog_len   <= ADDR_ZERO;
      running    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state_r)
        IDLE: begin
          core_reset <= 1'b0;
          running    <= 1'b0;
          if (load_start && !stop) begin
            state_r   <= LOAD;
            wr_ptr_r  <= ADDR_ZERO;
            wr_addr_r <= ADDR_ZERO;
            overflow  <= 1'b0;
            prog_len  <= ADDR_ZERO;
            in_ready  <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        LOAD: begin
          core_reset <= 1'b0;
          if (stop) begin
            state_r  <= IDLE;
            in_ready <= 1'b0;
          end else if (load_start) begin
            // Restart drops any byte accepted this cycle.
            wr_ptr_r  <= ADDR_ZERO;
            wr_addr_r <= ADDR_ZERO;
            overflow  <= 1'b0;
            prog_len  <= ADDR_ZERO;
          end else if (in_valid && in_ready) begin
            ram_we    <= 1'b1;
            wr_addr_r <= wr_ptr_r;
            wr_ptr_r  <= wr_ptr_r + ADDR_ONE;
            prog_len  <= wr_ptr_r + ADDR_ONE;
            if (in_data == END_CHAR) begin
              ram_wdata <= END_CHAR;
              state_r   <= RUN;
              running   <= 1'b1;
              in_ready  <= 1'b0;
            end else if (wr_ptr_r == LAST_ADDR) begin
              // Last slot always holds a terminator, even on overflow.
              ram_wdata <= END_CHAR;
              overflow  <= 1'b1;
              state_r   <= IDLE;
              in_ready  <= 1'b0;
            end else begin
              ram_wdata <= in_data;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_r    <= IDLE;
            running    <= 1'b0;
            core_reset <= 1'b0;
          end else if (load_start) begin
            state_r    <= LOAD;
            running    <= 1'b0;
            core_reset <= 1'b0;
            in_ready   <= 1'b1;
            wr_ptr_r   <= ADDR_ZERO;
            wr_addr_r  <= ADDR_ZERO;
            overflow   <= 1'b0;
            prog_len   <= ADDR_ZERO;
          end else begin
            // Released one edge after entry so the terminator write lands first.
            core_reset <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          running    <= 1'b0;
          core_reset <= 1'b0;
          in_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Code-RAM address mux: a pending write owns the port, otherwise the core in RUN.
  always_comb begin
    ram_addr = wr_addr_r;
    if (ram_we) begin
      ram_addr = wr_addr_r;
    end else if (state_r == RUN) begin
      ram_addr = core_addr_code;
    end else if (state_r == IDLE) begin
      ram_addr = ADDR_ZERO;
    end else begin
      ram_addr = wr_addr_r;
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader with a 16-byte code RAM.
module tb_bf_program_loader;
  import bf_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          stop;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] core_addr_code;
  logic          core_reset;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [AW-1:0] prog_len;
  logic          running;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int base;
  logic [7:0] log_addr [0:63];
  logic [7:0] log_data [0:63];
  logic [7:0] prog [0:4];

  bf_program_loader #(.CODE_AW(AW), .END_CHAR(8'h00)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .stop(stop),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_addr_code(core_addr_code), .core_reset(core_reset),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .prog_len(prog_len), .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Log every code-RAM write in order.
  always @(posedge clk) begin
    if (reset && ram_we && wcount < 64) begin
      log_addr[wcount] <= 8'(ram_addr);
      log_data[wcount] <= ram_wdata;
      wcount <= wcount + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic check_prog_log(input string tag, input int b);
    check({tag, "_count"}, wcount - b, 5);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_addr"}, log_addr[b+i], i);
      check({tag, "_data"}, log_data[b+i], prog[i]);
    end
  endtask

  initial begin
    prog[0] = 8'h2B; prog[1] = 8'h2B; prog[2] = 8'h2B; prog[3] = 8'h2E; prog[4] = 8'h00;
    reset = 1'b0; load_start = 1'b0; stop = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; core_addr_code = '0;

    // Reset values
    repeat (3) step();
    check("rst_core_reset", core_reset, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_running", running, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    reset = 1'b1;
    step();
    check("idle_in_ready", in_ready, 0);

    // Continuous load of "+++." plus terminator
    pulse_start();
    check("load_in_ready", in_ready, 1);
    base = wcount;
    for (int i = 0; i < 5; i++) push(prog[i]);
    check("term_we", ram_we, 1);
    check("term_addr", ram_addr, 4);
    check("term_data", ram_wdata, 8'h00);
    check("term_running", running, 1);
    check("term_core_reset", core_reset, 0);
    check("term_in_ready", in_ready, 0);
    step();
    check("run_core_reset", core_reset, 1);
    check("run_we", ram_we, 0);
    check("run_prog_len", prog_len, 5);
    core_addr_code = 4'hA;
    #1 check("run_mux_a", ram_addr, 4'hA);
    core_addr_code = 4'h3;
    #1 check("run_mux_3", ram_addr, 4'h3);
    check_prog_log("cont", base);

    // Reload from RUN with 3-cycle gaps between bytes
    pulse_start();
    check("reload_core_reset", core_reset, 0);
    check("reload_running", running, 0);
    check("reload_in_ready", in_ready, 1);
    check("reload_prog_len", prog_len, 0);
    base = wcount;
    for (int i = 0; i < 5; i++) begin
      push(prog[i]);
      if (i < 4) begin
        repeat (3) step();
        check("gap_no_write", wcount - base, i + 1);
      end
    end
    repeat (3) step();
    check("gap_running", running, 1);
    check("gap_core_reset", core_reset, 1);
    check("gap_prog_len", prog_len, 5);
    check_prog_log("gap", base);

    // Overflow: 16 non-terminator bytes into a 16-byte RAM
    pulse_start();
    base = wcount;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check("ovf_we", ram_we, 1);
    check("ovf_addr", ram_addr, 4'hF);
    check("ovf_data", ram_wdata, 8'h00);
    check("ovf_flag", overflow, 1);
    check("ovf_running", running, 0);
    check("ovf_in_ready", in_ready, 0);
    step();
    check("ovf_core_reset", core_reset, 0);
    check("ovf_idle_we", ram_we, 0);
    check("ovf_idle_addr", ram_addr, 0);
    check("ovf_count", wcount - base, 16);
    for (int i = 0; i < 15; i++) begin
      check("ovf_log_addr", log_addr[base+i], i);
      check("ovf_log_data", log_data[base+i], 8'h10 + 8'(i));
    end
    check("ovf_last_addr", log_addr[base+15], 4'hF);
    check("ovf_last_data", log_data[base+15], 8'h00);

    // stop and load_start together mid-load
    pulse_start();
    check("stop_ovf_cleared", overflow, 0);
    base = wcount;
    push(8'h41);
    push(8'h42);
    in_data = 8'h55; in_valid = 1'b1; stop = 1'b1; load_start = 1'b1;
    step();
    in_valid = 1'b0; stop = 1'b0; load_start = 1'b0;
    check("stop_in_ready", in_ready, 0);
    check("stop_running", running, 0);
    check("stop_we", ram_we, 0);
    check("stop_prog_len", prog_len, 2);
    check("stop_ram_addr", ram_addr, 0);
    in_valid = 1'b1; in_data = 8'h66;
    repeat (3) step();
    in_valid = 1'b0;
    check("stop_count", wcount - base, 2);
    check("stop_core_reset", core_reset, 0);

    // Asynchronous reset while running
    pulse_start();
    push(8'h2E);
    push(8'h00);
    step();
    check("pre_rst_core_reset", core_reset, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_core_reset", core_reset, 0);
    check("mid_rst_running", running, 0);
    check("mid_rst_prog_len", prog_len, 0);
    step();
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
